// File: rtl/lcd1602_bus_monitor.sv
// Receive-side model of the HD44780 write bus: decodes E-falling-edge transfers into a
// 32-cell DDRAM shadow plus cursor, display and function-set state.
module lcd1602_bus_monitor #(
  parameter int          MIN_E_HIGH = 2,
  parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       disp_on,
  output logic       func_8bit,
  output logic       two_line,
  output logic       busy,
  output logic       wr_strobe,
  output logic       wr_is_data,
  output logic [7:0] wr_byte,
  output logic [7:0] err_count
);

  localparam int CW = $clog2(MIN_E_HIGH + 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // Bus handshake: RS/RW/DATA must be stable while E is high; a transfer is taken on the
  // falling edge of the synchronised E if E stayed high for at least MIN_E_HIGH cycles.
  logic [10:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic          e_prev_q, e_prev_d;
  logic [CW-1:0] ecnt_q, ecnt_d;
  state_t        state_q, state_d;
  logic [4:0]    clr_idx_q, clr_idx_d;
  logic [4:0]    cursor_q, cursor_d;
  logic          inc_q, inc_d;
  logic          disp_q, disp_d;
  logic          f8_q, f8_d;
  logic          two_q, two_d;
  logic          strobe_q, strobe_d;
  logic          is_data_q, is_data_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    rd_char_q, rd_char_d;
  logic [7:0]    shadow_q [32];

  logic          e_s, rs_s, rw_s, fall, wide_ok, err_inc;
  logic [7:0]    d_s;
  logic          mem_we;
  logic [4:0]    mem_addr;
  logic [7:0]    mem_wdata;

  always_comb begin
    sync1_d   = {lcd_rs, lcd_rw, lcd_e, lcd_data};
    sync2_d   = sync1_q;
    rs_s      = sync2_q[10];
    rw_s      = sync2_q[9];
    e_s       = sync2_q[8];
    d_s       = sync2_q[7:0];
    e_prev_d  = e_s;
    fall      = e_prev_q & ~e_s;
    wide_ok   = (ecnt_q >= CW'(MIN_E_HIGH));
    rd_char_d = shadow_q[rd_addr];

    if (!e_s)                             ecnt_d = '0;
    else if (ecnt_q == CW'(MIN_E_HIGH))   ecnt_d = ecnt_q;
    else                                  ecnt_d = ecnt_q + 1'b1;

    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cursor_d  = cursor_q;
    inc_d     = inc_q;
    disp_d    = disp_q;
    f8_d      = f8_q;
    two_d     = two_q;
    strobe_d  = 1'b0;
    is_data_d = is_data_q;
    byte_d    = byte_q;
    err_inc   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = clr_idx_q;
    mem_wdata = FILL_CHAR;

    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q == 5'd31) state_d = ST_IDLE;
    end

    if (fall) begin
      if (!wide_ok || rw_s || state_q == ST_CLEAR) begin
        err_inc = 1'b1;
      end else begin
        strobe_d  = 1'b1;
        is_data_d = rs_s;
        byte_d    = d_s;
        if (rs_s) begin
          mem_we    = 1'b1;
          mem_addr  = cursor_q;
          mem_wdata = d_s;
          cursor_d  = inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
        end else begin
          // Instruction class is set by the highest '1' bit of the byte.
          casez (d_s)
            8'b1???????: begin
              if (d_s[6:4] == 3'b000)      cursor_d = {1'b0, d_s[3:0]};
              else if (d_s[6:4] == 3'b100) cursor_d = {1'b1, d_s[3:0]};
              else                         err_inc  = 1'b1;
            end
            8'b001?????: begin
              f8_d  = d_s[4];
              two_d = d_s[3];
            end
            8'b00001???: disp_d = d_s[2];
            8'b000001??: inc_d  = d_s[1];
            8'b0000001?: cursor_d = 5'd0;
            8'b00000001: begin
              cursor_d  = 5'd0;
              inc_d     = 1'b1;
              state_d   = ST_CLEAR;
              clr_idx_d = 5'd0;
            end
            default: ;
          endcase
        end
      end
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      e_prev_q  <= 1'b0;
      ecnt_q    <= '0;
      state_q   <= ST_CLEAR;
      clr_idx_q <= 5'd0;
      cursor_q  <= 5'd0;
      inc_q     <= 1'b1;
      disp_q    <= 1'b0;
      f8_q      <= 1'b1;
      two_q     <= 1'b0;
      strobe_q  <= 1'b0;
      is_data_q <= 1'b0;
      byte_q    <= 8'd0;
      err_q     <= 8'd0;
      rd_char_q <= 8'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      e_prev_q  <= e_prev_d;
      ecnt_q    <= ecnt_d;
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cursor_q  <= cursor_d;
      inc_q     <= inc_d;
      disp_q    <= disp_d;
      f8_q      <= f8_d;
      two_q     <= two_d;
      strobe_q  <= strobe_d;
      is_data_q <= is_data_d;
      byte_q    <= byte_d;
      err_q     <= err_d;
      rd_char_q <= rd_char_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) shadow_q[mem_addr] <= mem_wdata;
  end

  assign rd_char    = rd_char_q;
  assign cursor     = cursor_q;
  assign disp_on    = disp_q;
  assign func_8bit  = f8_q;
  assign two_line   = two_q;
  assign busy       = (state_q == ST_CLEAR);
  assign wr_strobe  = strobe_q;
  assign wr_is_data = is_data_q;
  assign wr_byte    = byte_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_lcd1602_bus_monitor.sv
// Bench for lcd1602_bus_monitor: directed LCD traffic plus random transfers checked
// against a transaction-level model of the display shadow and status.
module tb_lcd1602_bus_monitor;

  localparam int MIN_E_HIGH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_data = 8'd0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char, wr_byte, err_count;
  logic [4:0] cursor;
  logic       disp_on, func_8bit, two_line, busy, wr_strobe, wr_is_data;

  always #10 clk = ~clk;

  lcd1602_bus_monitor #(.MIN_E_HIGH(MIN_E_HIGH), .FILL_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor),
    .disp_on(disp_on), .func_8bit(func_8bit), .two_line(two_line), .busy(busy),
    .wr_strobe(wr_strobe), .wr_is_data(wr_is_data), .wr_byte(wr_byte),
    .err_count(err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;

  always @(negedge clk) if (wr_strobe) strobe_cnt++;

  // Reference model: one update per bus transaction.
  logic [7:0] m_shadow [32];
  int         m_cursor, m_err, m_strobes;
  bit         m_inc, m_disp, m_f8, m_two, m_busy, m_last_rs;
  logic [7:0] m_last_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
    m_cursor = 0; m_inc = 1; m_disp = 0; m_f8 = 1; m_two = 0;
    m_err = 0; m_last_byte = 8'd0; m_last_rs = 0; m_busy = 1;
  endtask

  task automatic model_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_xfer(input bit rs, input bit rw, input logic [7:0] d, input int ehigh);
    int a;
    if (ehigh < MIN_E_HIGH || rw || m_busy) begin
      model_err();
      return;
    end
    m_strobes++;
    m_last_rs = rs;
    m_last_byte = d;
    if (rs) begin
      m_shadow[m_cursor] = d;
      m_cursor = m_inc ? (m_cursor + 1) % 32 : (m_cursor + 31) % 32;
    end else if (d == 1) begin
      for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
      m_cursor = 0; m_inc = 1; m_busy = 1;
    end else if (d >= 2 && d < 4) begin
      m_cursor = 0;
    end else if (d >= 4 && d < 8) begin
      m_inc = d[1];
    end else if (d >= 8 && d < 16) begin
      m_disp = d[2];
    end else if (d >= 32 && d < 64) begin
      m_f8 = d[4]; m_two = d[3];
    end else if (d >= 128) begin
      a = int'(d) - 128;
      if (a < 16) m_cursor = a;
      else if (a >= 64 && a < 80) m_cursor = 16 + (a - 64);
      else model_err();
    end
  endtask

  task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d, input int ehigh);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b0;
    @(posedge clk); #1;
    lcd_e = 1'b1;
    repeat (ehigh) @(posedge clk);
    #1 lcd_e = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    model_xfer(rs, rw, d, ehigh);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cursor"}, cursor, m_cursor);
    check({tag, "_disp"}, disp_on, m_disp);
    check({tag, "_f8"}, func_8bit, m_f8);
    check({tag, "_two"}, two_line, m_two);
    check({tag, "_err"}, err_count, m_err);
    check({tag, "_strobes"}, strobe_cnt, m_strobes);
    check({tag, "_wrbyte"}, wr_byte, m_last_byte);
    check({tag, "_isdata"}, wr_is_data, m_last_rs);
    check({tag, "_busy"}, busy, m_busy);
  endtask

  task automatic wait_clear(input string tag);
    repeat (40) @(posedge clk);
    #1;
    m_busy = 0;
    check({tag, "_busy_done"}, busy, 1'b0);
  endtask

  task automatic check_cells(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(posedge clk); #1;
      check($sformatf("%s_cell%0d", tag, i), rd_char, m_shadow[i]);
    end
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check({tag, "_rd_char"}, rd_char, 8'd0);
    check({tag, "_cursor"}, cursor, 5'd0);
    check({tag, "_err"}, err_count, 8'd0);
    check({tag, "_strobe"}, wr_strobe, 1'b0);
    check({tag, "_wrbyte"}, wr_byte, 8'd0);
    check({tag, "_f8"}, func_8bit, 1'b1);
    check({tag, "_disp"}, disp_on, 1'b0);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check({tag, "_busy_after"}, busy, 1'b1);
    wait_clear(tag);
    check_state(tag);
  endtask

  initial begin
    bit         rs, rw;
    int         eh;
    logic [7:0] d;

    m_strobes = 0;
    model_reset();

    // 1: power-on reset and clear-fill
    do_reset("t1", 3);
    check_cells("t1");

    // 2: init sequence then "HI"
    bus_xfer(0, 0, 8'h38, 4);
    bus_xfer(0, 0, 8'h0C, 4);
    bus_xfer(0, 0, 8'h06, 4);
    bus_xfer(1, 0, 8'h48, 4);
    bus_xfer(1, 0, 8'h49, 4);
    check_state("t2");
    check("t2_cursor_abs", cursor, 5'd2);
    check("t2_two_abs", two_line, 1'b1);
    check_cells("t2");

    // 3: line-2 address and line-1 end wrapping into line 2
    bus_xfer(0, 0, 8'hC0, 4);
    bus_xfer(1, 0, 8'h41, 4);
    bus_xfer(0, 0, 8'h8F, 4);
    bus_xfer(1, 0, 8'h42, 4);
    bus_xfer(1, 0, 8'h42, 4);
    check_state("t3");
    check("t3_cursor_abs", cursor, 5'd17);
    check_cells("t3");

    // 4: decrement through index 0, then clear
    bus_xfer(0, 0, 8'h04, 4);
    bus_xfer(0, 0, 8'h80, 4);
    bus_xfer(1, 0, 8'h5A, 4);
    check_state("t4a");
    check("t4_cursor_wrap", cursor, 5'd31);
    check_cells("t4a");
    bus_xfer(0, 0, 8'h01, 4);
    check_state("t4b");
    wait_clear("t4b");
    check_state("t4c");
    check_cells("t4c");

    // 5: protocol errors
    do_reset("t5r", 2);
    bus_xfer(1, 0, 8'h77, 1);
    bus_xfer(1, 1, 8'h66, 4);
    bus_xfer(0, 0, 8'hA0, 4);
    bus_xfer(0, 0, 8'h01, 4);
    bus_xfer(1, 0, 8'h99, 4);
    check_state("t5a");
    wait_clear("t5");
    check("t5_err_abs", err_count, 8'd4);
    check_state("t5b");
    check_cells("t5");

    // 6: reset while E is high, then reset mid-clear
    bus_xfer(1, 0, 8'h31, 4);
    @(posedge clk); #1;
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h55; lcd_e = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 lcd_e = 1'b0;
    do_reset("t6a", 2);
    bus_xfer(0, 0, 8'h01, 4);
    repeat (8) @(posedge clk);
    do_reset("t6b", 2);
    check_cells("t6");

    // error counter saturation
    for (int i = 0; i < 258; i++) bus_xfer(1, 0, 8'($urandom_range(0, 255)), 1);
    check_state("sat");
    check("sat_abs", err_count, 8'hFF);
    do_reset("sat_r", 2);

    // random traffic
    for (int it = 0; it < 200; it++) begin
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 19) == 0);
      eh = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0:       d = 8'h80 | 8'($urandom_range(0, 15));
        1:       d = 8'hC0 | 8'($urandom_range(0, 15));
        default: d = 8'($urandom_range(0, 255));
      endcase
      bus_xfer(rs, rw, d, eh);
      check_state($sformatf("rnd%0d", it));
      if (m_busy) wait_clear($sformatf("rnd%0d", it));
      if (it % 40 == 39) check_cells($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
